// File: rtl/clock_pkg.sv
// Shared definitions for the timer preset editor.
//   edit_state_e     : editor FSM encoding
//   HOUR_MAX_DEFAULT : default highest hour (17:59:59 fits a 16-bit seconds count)
//   BCD_59           : wrap limit for minute and second fields
//   to_bcd8()        : elaboration-time conversion of a small integer constant to BCD
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EDIT_HOUR = 2'd1,
    ST_EDIT_MIN  = 2'd2,
    ST_EDIT_SEC  = 2'd3
  } edit_state_e;

  localparam int          HOUR_MAX_DEFAULT = 17;
  localparam logic [7:0]  BCD_59           = 8'h59;

  // Only used on parameters; field arithmetic itself stays in BCD.
  function automatic logic [7:0] to_bcd8(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_field.sv
// One two-digit BCD register with wrap-around increment/decrement and a
// load path used to restore the pre-edit value.
//   clk, rst_n : clock, asynchronous active-low reset (value -> 00)
//   inc, dec   : one-cycle step requests (caller never asserts both)
//   load       : load load_val (highest priority)
//   load_val   : value to restore, assumed legal BCD
//   value      : current BCD value, always within 00..MAX_BCD
module bcd_field
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX_BCD = BCD_59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value
);

  logic [7:0] inc_val;
  logic [7:0] dec_val;

  // Digit-wise carry/borrow keeps every intermediate a legal BCD code.
  always_comb begin
    inc_val = 8'h00;
    if (value == MAX_BCD)
      inc_val = 8'h00;
    else if (value[3:0] == 4'h9)
      inc_val = {value[7:4] + 4'h1, 4'h0};
    else
      inc_val = {value[7:4], value[3:0] + 4'h1};
  end

  always_comb begin
    dec_val = 8'h00;
    if (value == 8'h00)
      dec_val = MAX_BCD;
    else if (value[3:0] == 4'h0)
      dec_val = {value[7:4] - 4'h1, 4'h9};
    else
      dec_val = {value[7:4], value[3:0] - 4'h1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      value <= 8'h00;
    else if (load)
      value <= load_val;
    else if (inc)
      value <= inc_val;
    else if (dec)
      value <= dec_val;
  end

endmodule

// File: rtl/timer_set_editor.sv
// Button-driven editor for the countdown timer preset (HH:MM:SS in BCD).
//   clk, rst_n          : clock, asynchronous active-low reset
//   tick_1hz, tick_2hz  : one-cycle strobes (timeout base, blink base)
//   btn_mode/up/down/confirm : one-cycle debounced button pulses
//   hour_bcd, minute_bcd, second_bcd : preset value
//   set_timer           : one-cycle commit strobe
//   editing             : high outside IDLE
//   blank_mask          : {hour, minute, second} display blanking
// Same-cycle button priority: confirm > mode > up/down; up+down is a no-op.
module timer_set_editor
  import clock_pkg::*;
#(
  parameter int HOUR_MAX  = HOUR_MAX_DEFAULT,
  parameter int TIMEOUT_S = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_confirm,
  output logic [7:0] hour_bcd,
  output logic [7:0] minute_bcd,
  output logic [7:0] second_bcd,
  output logic       set_timer,
  output logic       editing,
  output logic [2:0] blank_mask
);

  localparam int CW = $clog2(TIMEOUT_S + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_S - 1);

  edit_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          set_d;
  logic          snap;
  logic          restore;
  logic [2:0]    inc_f, dec_f;     // {hour, minute, second}
  logic [23:0]   backup_q;
  logic [2:0]    sel_d;

  // Bit position of the field owned by each edit state.
  function automatic logic [2:0] field_sel(input edit_state_e s);
    case (s)
      ST_EDIT_HOUR: return 3'b100;
      ST_EDIT_MIN:  return 3'b010;
      ST_EDIT_SEC:  return 3'b001;
      default:      return 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      set_timer  <= 1'b0;
      editing    <= 1'b0;
      blank_mask <= 3'b000;
      backup_q   <= 24'h000000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      set_timer  <= set_d;
      editing    <= (state_d != ST_IDLE);
      blank_mask <= phase_d ? sel_d : 3'b000;
      if (snap)
        backup_q <= {hour_bcd, minute_bcd, second_bcd};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    set_d   = 1'b0;
    snap    = 1'b0;
    restore = 1'b0;
    inc_f   = 3'b000;
    dec_f   = 3'b000;

    if (state_q == ST_IDLE) begin
      cnt_d   = '0;
      phase_d = 1'b0;
      if (btn_confirm) begin
        set_d = 1'b1;
      end else if (btn_mode) begin
        state_d = ST_EDIT_HOUR;
        snap    = 1'b1;
        phase_d = 1'b1;
      end
    end else begin
      if (btn_confirm) begin
        state_d = ST_IDLE;
        set_d   = 1'b1;
        cnt_d   = '0;
        phase_d = 1'b0;
      end else if (btn_mode) begin
        case (state_q)
          ST_EDIT_HOUR: state_d = ST_EDIT_MIN;
          ST_EDIT_MIN:  state_d = ST_EDIT_SEC;
          default:      state_d = ST_EDIT_HOUR;
        endcase
        cnt_d   = '0;
        phase_d = 1'b1;
      end else if (btn_up ^ btn_down) begin
        inc_f   = btn_up   ? field_sel(state_q) : 3'b000;
        dec_f   = btn_down ? field_sel(state_q) : 3'b000;
        cnt_d   = '0;
        phase_d = 1'b1;
      end else if (btn_up && btn_down) begin
        // Both pressed: nothing changes, but it still counts as activity.
        cnt_d = '0;
        if (tick_2hz)
          phase_d = ~phase_q;
      end else if (tick_1hz && (cnt_q == CNT_LAST)) begin
        state_d = ST_IDLE;
        restore = 1'b1;
        cnt_d   = '0;
        phase_d = 1'b0;
      end else begin
        if (tick_1hz)
          cnt_d = cnt_q + CW'(1);
        if (tick_2hz)
          phase_d = ~phase_q;
      end
    end

    sel_d = field_sel(state_d);
  end

  bcd_field #(.MAX_BCD(to_bcd8(HOUR_MAX))) u_hour (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (inc_f[2]),
    .dec      (dec_f[2]),
    .load     (restore),
    .load_val (backup_q[23:16]),
    .value    (hour_bcd)
  );

  bcd_field #(.MAX_BCD(BCD_59)) u_minute (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (inc_f[1]),
    .dec      (dec_f[1]),
    .load     (restore),
    .load_val (backup_q[15:8]),
    .value    (minute_bcd)
  );

  bcd_field #(.MAX_BCD(BCD_59)) u_second (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (inc_f[0]),
    .dec      (dec_f[0]),
    .load     (restore),
    .load_val (backup_q[7:0]),
    .value    (second_bcd)
  );

endmodule

// File: tb/tb_timer_set_editor.sv
// Directed bench for timer_set_editor. A behavioural model (decimal integer
// arithmetic) predicts the full output word each cycle; predictions go into
// exp_q when the stimulus is driven and are popped after the clock edge.
module tb_timer_set_editor;

  localparam int HOUR_MAX  = 17;
  localparam int TIMEOUT_S = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0, tick_2hz = 1'b0;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_confirm = 1'b0;
  logic [7:0] hour_bcd, minute_bcd, second_bcd;
  logic       set_timer, editing;
  logic [2:0] blank_mask;

  int errors = 0;
  int checks = 0;

  // {hour, minute, second, set_timer, editing, blank_mask}
  logic [28:0] exp_q[$];

  // Model state
  int m_h, m_m, m_s, m_st, m_ph, m_cnt, b_h, b_m, b_s, m_set;

  timer_set_editor #(.HOUR_MAX(HOUR_MAX), .TIMEOUT_S(TIMEOUT_S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_1hz    (tick_1hz),
    .tick_2hz    (tick_2hz),
    .btn_mode    (btn_mode),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_confirm (btn_confirm),
    .hour_bcd    (hour_bcd),
    .minute_bcd  (minute_bcd),
    .second_bcd  (second_bcd),
    .set_timer   (set_timer),
    .editing     (editing),
    .blank_mask  (blank_mask)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r = 8'((v / 10) * 16 + (v % 10));
    return r;
  endfunction

  function automatic logic [28:0] observed();
    return {hour_bcd, minute_bcd, second_bcd, set_timer, editing, blank_mask};
  endfunction

  function automatic logic [28:0] model_word();
    logic [2:0] sel;
    sel = (m_st == 1) ? 3'b100 : (m_st == 2) ? 3'b010 : (m_st == 3) ? 3'b001 : 3'b000;
    return {bcd(m_h), bcd(m_m), bcd(m_s), m_set[0], (m_st != 0),
            (m_st != 0 && m_ph != 0) ? sel : 3'b000};
  endfunction

  task automatic check(input string tag, input logic [28:0] obs, input logic [28:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_st = 0; m_ph = 0; m_cnt = 0;
    b_h = 0; b_m = 0; b_s = 0; m_set = 0;
  endtask

  function automatic int wrap_up(input int v, input int mx);
    return (v == mx) ? 0 : v + 1;
  endfunction

  function automatic int wrap_dn(input int v, input int mx);
    return (v == 0) ? mx : v - 1;
  endfunction

  task automatic model_step(input logic m, u, d, c, t1, t2);
    m_set = 0;
    if (m_st == 0) begin
      m_ph = 0;
      if (c) m_set = 1;
      else if (m) begin
        m_st = 1; b_h = m_h; b_m = m_m; b_s = m_s; m_cnt = 0; m_ph = 1;
      end
    end else if (c) begin
      m_st = 0; m_set = 1; m_cnt = 0; m_ph = 0;
    end else if (m) begin
      m_st = (m_st == 3) ? 1 : m_st + 1; m_cnt = 0; m_ph = 1;
    end else if (u != d) begin
      case (m_st)
        1: m_h = u ? wrap_up(m_h, HOUR_MAX) : wrap_dn(m_h, HOUR_MAX);
        2: m_m = u ? wrap_up(m_m, 59) : wrap_dn(m_m, 59);
        default: m_s = u ? wrap_up(m_s, 59) : wrap_dn(m_s, 59);
      endcase
      m_cnt = 0; m_ph = 1;
    end else begin
      if (u && d) m_cnt = 0;
      else if (t1) m_cnt++;
      if (m_cnt == TIMEOUT_S) begin
        m_st = 0; m_h = b_h; m_m = b_m; m_s = b_s; m_cnt = 0; m_ph = 0;
      end else if (t2) m_ph = 1 - m_ph;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic m, u, d, c, t1, t2);
    logic [28:0] e;
    @(negedge clk);
    btn_mode = m; btn_up = u; btn_down = d; btn_confirm = c;
    tick_1hz = t1; tick_2hz = t2;
    model_step(m, u, d, c, t1, t2);
    exp_q.push_back(model_word());
    @(posedge clk);
    #1;
    btn_mode = 0; btn_up = 0; btn_down = 0; btn_confirm = 0;
    tick_1hz = 0; tick_2hz = 0;
    e = exp_q.pop_front();
    check("cycle", observed(), e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic mode();    step(1, 0, 0, 0, 0, 0); endtask
  task automatic up();      step(0, 1, 0, 0, 0, 0); endtask
  task automatic down();    step(0, 0, 1, 0, 0, 0); endtask
  task automatic confirm(); step(0, 0, 0, 1, 0, 0); endtask

  task automatic check_time(input string tag, input logic [23:0] t);
    check(tag, {5'b0, hour_bcd, minute_bcd, second_bcd}, {5'b0, t});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outputs", observed(), 29'h0);
    rst_n = 1'b1;
    idle(2);

    // Basic edit: 03:58:00, one-cycle commit strobe.
    mode(); up(); up(); up(); mode(); down(); down();
    confirm();
    check("commit_strobe", {28'h0, set_timer}, 29'h1);
    check_time("commit_035800", 24'h035800);
    idle(1);
    check("strobe_single", {27'h0, set_timer, editing}, 29'h0);

    // Hour wrap both ways.
    mode(); down(); down(); down();
    check_time("hour_at_00", 24'h005800);
    down();
    check_time("hour_dn_wrap_17", 24'h175800);
    up();
    check_time("hour_up_wrap_00", 24'h005800);
    // Minute: 58 -> ... -> 09, then BCD carry to 10.
    mode();
    for (int i = 0; i < 11; i++) up();
    check_time("minute_09", 24'h000900);
    up();
    check_time("minute_carry_10", 24'h001000);
    // Second: 00 down -> 59, up -> 00.
    mode(); down();
    check_time("second_dn_wrap_59", 24'h001059);
    up();
    check_time("second_up_wrap_00", 24'h001000);

    // up+down together: no change; then confirm+mode: commit wins.
    step(0, 1, 1, 0, 0, 0);
    check_time("up_down_noop", 24'h001000);
    step(1, 0, 0, 1, 0, 0);
    check("confirm_over_mode", {27'h0, set_timer, editing}, 29'h2);

    // Confirm in IDLE re-issues the strobe.
    confirm();
    check("idle_reconfirm", {27'h0, set_timer, editing}, 29'h2);

    // Commit 01:00:00.
    mode(); up(); mode();
    for (int i = 0; i < 10; i++) down();
    confirm();
    check_time("commit_010000", 24'h010000);

    // Edit to 05:00:00 then abandon via timeout.
    mode();
    for (int i = 0; i < 4; i++) up();
    check_time("edited_050000", 24'h050000);
    for (int i = 0; i < TIMEOUT_S - 1; i++) begin
      step(0, 0, 0, 0, 1, 0);
      idle(1);
    end
    check("timeout_not_yet", {28'h0, editing}, 29'h1);
    step(0, 0, 0, 0, 1, 0);
    check_time("timeout_restore", 24'h010000);
    check("timeout_idle", {27'h0, set_timer, editing}, 29'h0);
    idle(2);

    // Blink in EDIT_MIN.
    mode(); mode();
    check("blink_min_on", {26'h0, blank_mask}, 29'h2);
    step(0, 0, 0, 0, 0, 1);
    check("blink_min_off", {26'h0, blank_mask}, 29'h0);
    step(0, 0, 0, 0, 0, 1);
    check("blink_min_on2", {26'h0, blank_mask}, 29'h2);
    confirm();
    step(0, 0, 0, 0, 0, 1);
    check("blink_idle", {26'h0, blank_mask}, 29'h0);

    // Asynchronous reset during EDIT_SEC.
    mode(); mode(); mode(); up();
    check("in_edit_sec", {26'h0, blank_mask}, 29'h1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", observed(), 29'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
